// File: rtl/ca_ingr_snd_protocol_error_collector.sv
`default_nettype none
// ============================================================================
// Module   : ca_ingr_snd_protocol_error_collector
// Purpose  : Collects protocol errors reported by the ingress-send monitor.
//            Masked error bits accumulate into a sticky vector. The first
//            error word of an epoch is captured together with its timestamp.
//            Error cycles are counted with saturation, and a one-cycle
//            interrupt pulses whenever new sticky bits appear. Software
//            starts a new epoch through a 4-phase clear_req/clear_ack
//            handshake.
// Ports    : ap_clk, ap_rst           - clock, async active-high reset
//            protocol_error[_ap_vld]  - error word and its valid strobe
//            error_mask               - 1 = ignore that error bit
//            clear_req / clear_ack    - 4-phase clear handshake
//            err_sticky, err_first, err_first_ts, err_count,
//            err_any, err_irq         - collected error state
// Revision : 1.0 - initial release
// ============================================================================
module ca_ingr_snd_protocol_error_collector #(
  parameter int ERR_WIDTH = 16,
  parameter int CNT_WIDTH = 16,
  parameter int TS_WIDTH  = 32
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [ERR_WIDTH-1:0] protocol_error,
  input  logic                 protocol_error_ap_vld,
  input  logic [ERR_WIDTH-1:0] error_mask,
  input  logic                 clear_req,
  output logic                 clear_ack,
  output logic [ERR_WIDTH-1:0] err_sticky,
  output logic [ERR_WIDTH-1:0] err_first,
  output logic [TS_WIDTH-1:0]  err_first_ts,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_any,
  output logic                 err_irq
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCHED = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  state_t r_state;
  state_t w_state_nxt;

  logic [TS_WIDTH-1:0]  r_ts;
  logic [ERR_WIDTH-1:0] r_sticky;
  logic [ERR_WIDTH-1:0] r_first;
  logic [TS_WIDTH-1:0]  r_first_ts;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_irq;
  logic                 r_clear_ack;

  logic [ERR_WIDTH-1:0] w_masked;
  logic                 w_event;
  logic                 w_clear;
  logic [ERR_WIDTH-1:0] w_sticky_base;
  logic [CNT_WIDTH-1:0] w_count_base;
  logic                 w_first;
  logic                 w_new_bits;
  logic [ERR_WIDTH-1:0] w_sticky_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [ERR_WIDTH-1:0] w_first_nxt;
  logic [TS_WIDTH-1:0]  w_first_ts_nxt;

  // --------------------------------------------------------------------------
  // Collection datapath. A clear accepted this cycle turns the current state
  // into an empty epoch *before* the incoming event is applied, so an error
  // arriving together with the clear becomes the first error of the new epoch.
  // --------------------------------------------------------------------------
  always_comb begin
    w_masked      = protocol_error & ~error_mask;
    w_event       = protocol_error_ap_vld && (w_masked != '0);
    // clear_req held high while already acknowledging must not re-clear
    w_clear       = clear_req && (r_state != ST_ACK);
    w_sticky_base = w_clear ? '0 : r_sticky;
    w_count_base  = w_clear ? '0 : r_count;
    w_first       = w_event && (w_count_base == '0);
    w_new_bits    = w_event && ((w_masked & ~w_sticky_base) != '0);

    w_sticky_nxt = w_event ? (w_sticky_base | w_masked) : w_sticky_base;

    w_count_nxt = w_count_base;
    if (w_event) begin
      if (w_first)
        w_count_nxt = c_cnt_one;
      else if (w_count_base != c_cnt_max)
        w_count_nxt = w_count_base + c_cnt_one;
    end

    w_first_nxt    = w_clear ? '0 : r_first;
    w_first_ts_nxt = w_clear ? '0 : r_first_ts;
    if (w_first) begin
      w_first_nxt    = w_masked;
      w_first_ts_nxt = r_ts;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake state machine
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clear_req)
          w_state_nxt = ST_ACK;
        else if (w_event)
          w_state_nxt = ST_LATCHED;
      end
      ST_LATCHED: begin
        if (clear_req)
          w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        // Leave toward whichever state matches the epoch collected so far
        if (!clear_req)
          w_state_nxt = (w_count_nxt != '0) ? ST_LATCHED : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registered outputs and free-running timestamp
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ts        <= '0;
      r_sticky    <= '0;
      r_first     <= '0;
      r_first_ts  <= '0;
      r_count     <= '0;
      r_irq       <= 1'b0;
      r_clear_ack <= 1'b0;
    end else begin
      r_ts        <= r_ts + TS_WIDTH'(1);
      r_sticky    <= w_sticky_nxt;
      r_first     <= w_first_nxt;
      r_first_ts  <= w_first_ts_nxt;
      r_count     <= w_count_nxt;
      r_irq       <= w_new_bits;
      r_clear_ack <= (w_state_nxt == ST_ACK);
    end
  end

  assign clear_ack    = r_clear_ack;
  assign err_sticky   = r_sticky;
  assign err_first    = r_first;
  assign err_first_ts = r_first_ts;
  assign err_count    = r_count;
  assign err_any      = |r_sticky;
  assign err_irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ca_ingr_snd_protocol_error_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_ingr_snd_protocol_error_collector
// Purpose  : Self-checking bench. Drives a default-width collector and a
//            narrow one (4-bit counter, 4-bit timestamp) from the same
//            stimulus and compares both against an epoch-level reference
//            model (unbounded event count and cycle number, saturated or
//            wrapped only at comparison time).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_ingr_snd_protocol_error_collector;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [15:0] protocol_error = '0;
  logic        protocol_error_ap_vld = 1'b0;
  logic [15:0] error_mask = '0;
  logic        clear_req = 1'b0;

  logic        clear_ack,  clear_ack_s;
  logic [15:0] err_sticky, err_sticky_s;
  logic [15:0] err_first,  err_first_s;
  logic [31:0] err_first_ts;
  logic [3:0]  err_first_ts_s;
  logic [15:0] err_count;
  logic [3:0]  err_count_s;
  logic        err_any, err_any_s;
  logic        err_irq, err_irq_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ap_clk = ~ap_clk;

  ca_ingr_snd_protocol_error_collector u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
    .error_mask(error_mask), .clear_req(clear_req), .clear_ack(clear_ack),
    .err_sticky(err_sticky), .err_first(err_first), .err_first_ts(err_first_ts),
    .err_count(err_count), .err_any(err_any), .err_irq(err_irq)
  );

  ca_ingr_snd_protocol_error_collector #(.CNT_WIDTH(4), .TS_WIDTH(4)) u_dut_small (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .protocol_error(protocol_error), .protocol_error_ap_vld(protocol_error_ap_vld),
    .error_mask(error_mask), .clear_req(clear_req), .clear_ack(clear_ack_s),
    .err_sticky(err_sticky_s), .err_first(err_first_s), .err_first_ts(err_first_ts_s),
    .err_count(err_count_s), .err_any(err_any_s), .err_irq(err_irq_s)
  );

  // ---------------------------------------------------------------- model
  logic [15:0] m_sticky, m_first;
  longint      m_first_t;   // cycle number of first error in the epoch
  longint      m_n;         // error cycles in the epoch, unbounded
  longint      m_t;         // clock edges since reset release
  bit          m_ack, m_irq;

  task automatic model_reset();
    m_sticky = '0; m_first = '0; m_first_t = 0; m_n = 0; m_t = 0;
    m_ack = 1'b0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] masked;
    bit          ev;
    masked = protocol_error & ~error_mask;
    ev     = protocol_error_ap_vld && (masked != 0);
    if (clear_req && !m_ack) begin
      m_sticky = '0; m_first = '0; m_first_t = 0; m_n = 0;
    end
    m_irq = ev && ((masked & ~m_sticky) != 0);
    if (ev) begin
      if (m_n == 0) begin
        m_first   = masked;
        m_first_t = m_t;
      end
      m_sticky = m_sticky | masked;
      m_n++;
    end
    m_ack = clear_req;
    m_t++;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("sticky",     64'(err_sticky),     64'(m_sticky));
    check("first",      64'(err_first),      64'(m_first));
    check("first_ts",   64'(err_first_ts),   64'(m_first_t % (64'd1 << 32)));
    check("count",      64'(err_count),      64'((m_n > 65535) ? 65535 : m_n));
    check("any",        64'(err_any),        64'(m_sticky != 0));
    check("irq",        64'(err_irq),        64'(m_irq));
    check("ack",        64'(clear_ack),      64'(m_ack));
    check("s_sticky",   64'(err_sticky_s),   64'(m_sticky));
    check("s_first",    64'(err_first_s),    64'(m_first));
    check("s_first_ts", 64'(err_first_ts_s), 64'(m_first_t % 16));
    check("s_count",    64'(err_count_s),    64'((m_n > 15) ? 15 : m_n));
    check("s_any",      64'(err_any_s),      64'(m_sticky != 0));
    check("s_irq",      64'(err_irq_s),      64'(m_irq));
    check("s_ack",      64'(clear_ack_s),    64'(m_ack));
  endtask

  // One clock: model consumes the inputs sampled at this edge, outputs are
  // compared 1 time unit later.
  task automatic tick();
    @(posedge ap_clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_zero_big"},
          64'({clear_ack, err_sticky, err_first, err_first_ts, err_count, err_any, err_irq}), 64'd0);
    check({tag, "_zero_small"},
          64'({clear_ack_s, err_sticky_s, err_first_s, err_first_ts_s, err_count_s, err_any_s, err_irq_s}), 64'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge ap_clk);
    check_all_zero("reset");
    ap_rst = 1'b0;

    // first error; its timestamp is the first edge after release (ts 0)
    protocol_error_ap_vld = 1'b1; protocol_error = 16'h0040;
    tick();
    check("tp1_sticky", 64'(err_sticky), 64'h0040);
    check("tp1_irq",    64'(err_irq), 64'd1);
    check("tp1_ts",     64'(err_first_ts), 64'd0);

    tick(); tick();
    protocol_error = 16'h0100;
    tick();
    check("tp2_count",  64'(err_count), 64'd4);
    check("tp2_sticky", 64'(err_sticky), 64'h0140);
    check("tp2_irq",    64'(err_irq), 64'd1);
    protocol_error_ap_vld = 1'b0;
    tick();

    // masked bits ignored; partially masked word adds only unmasked bits
    error_mask = 16'h0001; protocol_error_ap_vld = 1'b1; protocol_error = 16'h0001;
    tick();
    check("tp3_masked_irq", 64'(err_irq), 64'd0);
    protocol_error = 16'h0003;
    tick();
    check("tp3_sticky", 64'(err_sticky), 64'h0142);
    error_mask = '0;

    // clear together with an event: event opens the new epoch
    clear_req = 1'b1; protocol_error = 16'h2000;
    tick();
    check("tp4_sticky", 64'(err_sticky), 64'h2000);
    check("tp4_count",  64'(err_count), 64'd1);
    check("tp4_ack",    64'(clear_ack), 64'd1);
    protocol_error_ap_vld = 1'b0;
    repeat (3) tick();
    check("tp4_noreclr", 64'(err_count), 64'd1);
    clear_req = 1'b0;
    tick();
    check("tp4_ackdrop", 64'(clear_ack), 64'd0);

    // saturation of the narrow counter
    protocol_error_ap_vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      protocol_error = 16'(1) << $urandom_range(15, 0);
      tick();
    end
    check("sat_small", 64'(err_count_s), 64'd15);
    protocol_error_ap_vld = 1'b0;

    // randomized traffic, masks and clear handshakes
    for (int i = 0; i < 600; i++) begin
      protocol_error_ap_vld = ($urandom_range(2, 0) == 0);
      protocol_error = (16'(1) << $urandom_range(15, 0)) |
                       (($urandom_range(3, 0) == 0) ? 16'($urandom) : 16'h0);
      if ($urandom_range(39, 0) == 0)
        error_mask = 16'($urandom) & 16'($urandom);
      if ($urandom_range(7, 0) == 0)
        clear_req = ~clear_req;
      tick();
    end

    // async reset in the middle of a clear handshake
    protocol_error_ap_vld = 1'b0; error_mask = '0;
    clear_req = 1'b1;
    tick(); tick();
    check("mid_ack", 64'(clear_ack), 64'd1);
    #2;
    ap_rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    clear_req = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    protocol_error_ap_vld = 1'b1; protocol_error = 16'h0008;
    tick();
    check("post_rst_first", 64'(err_first), 64'h0008);
    check("post_rst_irq",   64'(err_irq), 64'd1);
    check("post_rst_ts",    64'(err_first_ts), 64'd0);
    protocol_error_ap_vld = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
